// File: rtl/clb_cfg_loader_if.sv
// Byte-serial bitstream channel into the CLB configuration loader.
// The producer drives data/valid and the loader answers with ready.
interface clb_cfg_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/clb_cfg_loader.sv
// Configuration loader for a row of CLB tiles: buffers one checksummed
// frame in shadow registers and commits it atomically to the tiles.
module clb_cfg_loader #(
    parameter int         N_CLB = 4,
    parameter logic [7:0] HDR   = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    clb_cfg_loader_if.slave        in_if,
    output logic [16*N_CLB-1:0]    lut_mem_flat,
    output logic [N_CLB-1:0]       sel_ff_flat,
    output logic                   clb_rst,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic                   busy
);

    localparam int NB = 3 * N_CLB;
    localparam int IW = $clog2(NB);
    localparam int TW = (N_CLB > 1) ? $clog2(N_CLB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHK,
        COMMIT
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  tile;
    logic [1:0]     phase;
    logic [7:0]     sum;
    logic [15:0]    sh_lut [N_CLB];
    logic [N_CLB-1:0] sh_sel;
    logic           fire;
    logic           hdr_hit;
    logic           sum_ok;

    assign fire    = in_if.in_valid & in_if.in_ready;
    assign hdr_hit = (in_if.in_data == HDR);
    assign sum_ok  = (in_if.in_data == sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (fire && hdr_hit) state_nx = LOAD;
            LOAD:   if (fire && idx == LAST) state_nx = CHK;
            CHK:    if (fire) state_nx = sum_ok ? COMMIT : IDLE;
            COMMIT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_if.in_ready = 1'b0;
        busy           = 1'b0;
        in_if.in_ready = !rst && (state != COMMIT);
        busy           = (state != IDLE);
    end

    // Frame bookkeeping and the committed (active) configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            tile         <= '0;
            phase        <= 2'd0;
            sum          <= 8'd0;
            lut_mem_flat <= '0;
            sel_ff_flat  <= '0;
            clb_rst      <= 1'b1;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire && hdr_hit) begin
                        idx      <= '0;
                        tile     <= '0;
                        phase    <= 2'd0;
                        sum      <= 8'd0;
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (fire) begin
                        sum <= sum ^ in_if.in_data;
                        idx <= idx + 1'b1;
                        if (phase == 2'd2) begin
                            phase <= 2'd0;
                            tile  <= tile + 1'b1;
                        end else begin
                            phase <= phase + 2'd1;
                        end
                    end
                end
                CHK: begin
                    if (fire) begin
                        if (sum_ok) clb_rst <= 1'b1;
                        else        cfg_err <= 1'b1;
                    end
                end
                COMMIT: begin
                    for (int k = 0; k < N_CLB; k++) begin
                        lut_mem_flat[16*k +: 16] <= sh_lut[k];
                    end
                    sel_ff_flat <= sh_sel;
                    cfg_done    <= 1'b1;
                    clb_rst     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Shadow is plain data; its contents only matter after a full frame.
    always_ff @(posedge clk) begin
        if (state == LOAD && fire) begin
            unique case (phase)
                2'd0:    sh_lut[tile][7:0]  <= in_if.in_data;
                2'd1:    sh_lut[tile][15:8] <= in_if.in_data;
                default: sh_sel[tile]       <= in_if.in_data[0];
            endcase
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed plus randomized bench for clb_cfg_loader with N_CLB=4,
// checked against a frame-level reference model.
module tb_clb_cfg_loader;

    localparam int N  = 4;
    localparam int NB = 3 * N;
    localparam logic [7:0] HDR = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [16*N-1:0] lut_mem_flat;
    logic [N-1:0] sel_ff_flat;
    logic clb_rst;
    logic cfg_done;
    logic cfg_err;
    logic busy;

    clb_cfg_loader_if bus ();

    clb_cfg_loader #(.N_CLB(N), .HDR(HDR)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_if        (bus),
        .lut_mem_flat (lut_mem_flat),
        .sel_ff_flat  (sel_ff_flat),
        .clb_rst      (clb_rst),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    logic [7:0] pl [NB];
    logic [7:0] chk;
    logic [63:0] exp_lut;
    logic [3:0] exp_sel;
    logic exp_clbrst;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] s = 8'd0;
        foreach (pl[i]) s = s ^ pl[i];
        return s;
    endfunction

    function automatic logic [63:0] model_lut();
        logic [63:0] v = '0;
        for (int k = 0; k < N; k++) begin
            v = v | ({48'd0, pl[3*k+1], pl[3*k]} << (16 * k));
        end
        return v;
    endfunction

    function automatic logic [3:0] model_sel();
        logic [3:0] v = '0;
        for (int k = 0; k < N; k++) v[k] = pl[3*k+2][0];
        return v;
    endfunction

    task automatic model_reset();
        exp_lut = '0;
        exp_sel = '0;
        exp_clbrst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int g;
        int cnt;
        g = $urandom_range(gapmax, 0);
        bus.in_valid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        bus.in_data = b;
        bus.in_valid = 1'b1;
        cnt = 0;
        while (!bus.in_ready && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("ready_wait", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_ready", bus.in_ready, 0);
        check("rst_lut", lut_mem_flat, exp_lut);
        check("rst_sel", sel_ff_flat, exp_sel);
        check("rst_clbrst", clb_rst, 1);
        check("rst_done", cfg_done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", bus.in_ready, 1);
    endtask

    task automatic run_frame(input int gapmax, input bit overlap);
        send_byte(HDR, gapmax);
        check("hdr_done_clr", cfg_done, 0);
        check("hdr_err_clr", cfg_err, 0);
        check("hdr_busy", busy, 1);
        for (int i = 0; i < NB; i++) begin
            send_byte(pl[i], gapmax);
            check("load_lut_hold", lut_mem_flat, exp_lut);
            check("load_clbrst_hold", clb_rst, exp_clbrst);
        end
        send_byte(chk, gapmax);
        if (chk == xsum()) begin
            check("commit_ready", bus.in_ready, 0);
            check("commit_clbrst", clb_rst, 1);
            check("commit_lut_old", lut_mem_flat, exp_lut);
            exp_lut = model_lut();
            exp_sel = model_sel();
            exp_clbrst = 1'b0;
            if (!overlap) begin
                @(posedge clk);
                #1;
                check("new_lut", lut_mem_flat, exp_lut);
                check("new_sel", sel_ff_flat, exp_sel);
                check("new_done", cfg_done, 1);
                check("new_err", cfg_err, 0);
                check("new_clbrst", clb_rst, 0);
                check("new_ready", bus.in_ready, 1);
                check("new_busy", busy, 0);
            end else begin
                send_byte(HDR, 0);
                check("ovl_lut", lut_mem_flat, exp_lut);
                check("ovl_sel", sel_ff_flat, exp_sel);
                check("ovl_clbrst", clb_rst, 0);
                check("ovl_busy", busy, 1);
                check("ovl_done_clr", cfg_done, 0);
            end
        end else begin
            check("bad_err", cfg_err, 1);
            check("bad_done", cfg_done, 0);
            check("bad_busy", busy, 0);
            check("bad_lut", lut_mem_flat, exp_lut);
            check("bad_sel", sel_ff_flat, exp_sel);
            check("bad_clbrst", clb_rst, exp_clbrst);
        end
    endtask

    task automatic load_ref();
        logic [7:0] r [NB] = '{8'h00, 8'h80, 8'h01, 8'h96, 8'h69, 8'h00,
                               8'hFE, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00};
        foreach (pl[i]) pl[i] = r[i];
    endtask

    task automatic load_rand();
        foreach (pl[i]) pl[i] = 8'($urandom);
        chk = xsum();
    endtask

    initial begin
        int j;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // bad checksum on a fresh device
        load_ref();
        chk = 8'h7E;
        run_frame(0, 1'b0);

        // reference good frame, back-to-back
        chk = 8'h7F;
        run_frame(0, 1'b0);
        check("ref_lut_const", lut_mem_flat, 64'h0001_FFFE_6996_8000);
        check("ref_sel_const", sel_ff_flat, 4'b0101);

        // garbage, then gapped frame with an embedded header value
        send_byte(8'h00, 1);
        send_byte(8'h5A, 1);
        send_byte(8'h7F, 1);
        check("garbage_busy", busy, 0);
        load_ref();
        j = $urandom_range(NB - 1, 0);
        pl[j] = HDR;
        chk = xsum();
        run_frame(3, 1'b0);

        // abort mid-frame
        send_byte(HDR, 0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        do_reset();
        load_rand();
        run_frame(2, 1'b0);

        // randomized reloads over a committed config
        for (int r = 0; r < 4; r++) begin
            load_rand();
            if (r == 2) chk = chk ^ 8'h01;
            run_frame(2, 1'b0);
        end

        // new header offered during COMMIT must wait, not be lost
        load_rand();
        run_frame(1, 1'b1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clb_cfg_loader.md
# clb_cfg_loader

Configuration controller for a row of CLB tiles. Accepts a byte-serial bitstream over a valid/ready interface, buffers each tile's 16-bit LUT contents and FF-select bit in shadow registers, and checks an XOR checksum. On a good frame it commits the whole row atomically to the tiles' `lut_mem`/`sel_ff` inputs and holds the tiles in reset during the swap. Sits between the bitstream source and the CLB array.

## Interface
- `N_CLB`, default 4: number of CLB tiles configured; legal 1..64.
- `HDR`, default 8'hA5: frame header byte.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  bitstream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept; a byte transfers on an edge where `in_valid & in_ready`.
- `lut_mem_flat`  out  16*N_CLB  active LUT config; tile k = bits [16k+15:16k].
- `sel_ff_flat`  out  N_CLB  active FF-select; tile k = bit k.
- `clb_rst`  out  1  reset to the CLB flops.
- `cfg_done`  out  1  last frame committed successfully (sticky).
- `cfg_err`  out  1  last frame failed checksum (sticky).
- `busy`  out  1  state != IDLE.

## Operation
- Frame: `HDR`, then 3*N_CLB payload bytes, then 1 checksum byte. Total 3*N_CLB+2 bytes.
- Payload byte order: tile k uses payload bytes 3k, 3k+1, 3k+2.
  - Byte 3k goes to lut[7:0]; 3k+1 to lut[15:8].
  - Bit 0 of 3k+2 is sel_ff. Bits [7:1] are reserved: ignored, but still included in the checksum.
- Checksum = XOR of all 3*N_CLB payload bytes. The header is excluded.
- States: IDLE, LOAD, CHK, COMMIT.
  - IDLE: accepted byte == `HDR` → LOAD. On that edge, clear byte index, running XOR, `cfg_done`, `cfg_err`. Any other byte is dropped, state unchanged.
  - LOAD: each accepted byte is written to shadow slot [idx] and XORed into the running sum; idx increments. Value `HDR` is ordinary data here. Accepting idx == 3*N_CLB-1 → CHK.
  - CHK: accepted byte == running XOR → COMMIT. Mismatch → IDLE with `cfg_err`=1; shadow is discarded and active outputs are untouched.
  - COMMIT: lasts exactly one cycle, then → IDLE. On the edge leaving COMMIT:
    - shadow is copied to `lut_mem_flat`/`sel_ff_flat`;
    - `cfg_done` is set to 1;
    - `clb_rst` is cleared.
- `in_ready` is combinational: 1 in IDLE/LOAD/CHK, 0 in COMMIT and while `rst`=1.
- `clb_rst` is a register:
  - set by `rst`;
  - set on the edge entering COMMIT;
  - cleared on the edge leaving COMMIT;
  - otherwise holds.
  - Consequences: tiles stay in reset from reset until the first successful commit, and are reset for exactly the COMMIT cycle on each reload. A failed frame never changes `clb_rst`.
- Active config holds its old value throughout a reload until the commit edge.
- Byte index width is clog2(3*N_CLB). No wrap: the LOAD exit is decided by index compare.

## Timing
- Reset values:
  - state IDLE;
  - `lut_mem_flat`=0, `sel_ff_flat`=0;
  - `clb_rst`=1;
  - `cfg_done`=0, `cfg_err`=0, `busy`=0;
  - `in_ready`=0 during `rst`, 1 in the cycle after.
- `rst` mid-frame aborts the frame. All outputs return to reset values, including clearing a previously committed config.
- Back-to-back timing: if the header is accepted at edge t0 and the checksum at edge t0+3N+1, then COMMIT is the cycle after. New config, `cfg_done`=1 and `clb_rst`=0 are visible after edge t0+3N+2.
- Gaps in `in_valid` stall the FSM without penalty. Bytes offered during COMMIT wait (`in_ready`=0); they are not lost.
- `cfg_err` is asserted the cycle after the bad checksum edge.
- `cfg_done`/`cfg_err` are cleared the cycle after the next header is accepted.

## Test plan
- Reset with N_CLB=4 → `clb_rst`=1, `lut_mem_flat`=0, `sel_ff_flat`=0, `cfg_done`=0, `cfg_err`=0; `in_ready`=1 the cycle after `rst` falls.
- Good frame, back-to-back: A5 00 80 01 96 69 00 FE FF 01 01 00 00 7F → `lut_mem_flat`=64'h0001_FFFE_6996_8000, `sel_ff_flat`=4'b0101, `cfg_done`=1, `clb_rst` 1→0. Results appear 1 cycle after the checksum edge. `in_ready` is low for exactly 1 cycle.
- Same frame with checksum 7E → `cfg_err`=1, `cfg_done`=0, outputs still 0, `clb_rst` stays 1.
- Leading garbage 00 5A 7F, then the good frame with random `in_valid` gaps and one A5 payload byte substituted (checksum recomputed) → garbage is ignored, the A5 byte is treated as data, and the commit matches the expected values.
- `rst` after 5 payload bytes → all reset values. A following full good frame commits correctly.
- Second good frame after a successful commit → old config is held during LOAD/CHK. `clb_rst` is 1 only in the COMMIT cycle. The new values appear on the commit edge.
